// File: rtl/uart_rx_frame_checker_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_checker_pkg
// Shared definitions for the UART RX frame path: FSM state encoding, bit
// counter width and the legal data-width range. Intended to be shared with
// the RX FSM and the TX side so both agree on the encoding.
// -----------------------------------------------------------------------------
package uart_rx_frame_checker_pkg;

    localparam int STATE_W        = 3;
    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

    // Wide enough to count 0 .. DATA_WIDTH_MAX
    localparam int CNT_W = $clog2(DATA_WIDTH_MAX + 1);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_checker_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_checker_if
// Bundle between the RX edge/sample logic plus controller (master) and the
// frame checker (slave).
//   master drives : frame_start, sample_valid, sampled_bit, par_en, par_odd,
//                   stop2, err_clr_n
//   slave drives  : busy, data_out, data_valid, start_glitch, parity_error,
//                   stop_error, err_count
// -----------------------------------------------------------------------------
interface uart_rx_frame_checker_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
);

    logic                     frame_start;
    logic                     sample_valid;
    logic                     sampled_bit;
    logic                     par_en;
    logic                     par_odd;
    logic                     stop2;
    logic                     err_clr_n;

    logic                     busy;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     data_valid;
    logic                     start_glitch;
    logic                     parity_error;
    logic                     stop_error;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output frame_start, sample_valid, sampled_bit, par_en, par_odd, stop2, err_clr_n,
        input  busy, data_out, data_valid, start_glitch, parity_error, stop_error, err_count
    );

    modport slave (
        input  frame_start, sample_valid, sampled_bit, par_en, par_odd, stop2, err_clr_n,
        output busy, data_out, data_valid, start_glitch, parity_error, stop_error, err_count
    );

endinterface

// File: rtl/uart_rx_frame_checker_parity.sv
// -----------------------------------------------------------------------------
// uart_rx_parity_calc
// Combinational parity helper, usable by both RX checking and TX generation.
//   data_i     : data word
//   par_bit_i  : received parity bit (tie low when generating)
//   odd_i      : 1 = odd parity, 0 = even
//   par_bit_o  : parity bit a transmitter would send for data_i
//   par_err_o  : 1 when par_bit_i disagrees with par_bit_o
// -----------------------------------------------------------------------------
module uart_rx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_bit_i,
    input  logic                  odd_i,
    output logic                  par_bit_o,
    output logic                  par_err_o
);

    function automatic logic xor_reduce(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Even parity bit equals the XOR of the data; odd parity inverts it
    assign par_bit_o = xor_reduce(data_i) ^ odd_i;
    assign par_err_o = par_bit_o ^ par_bit_i;

endmodule

// File: rtl/uart_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_checker
// Walks one UART frame from the oversampled bit stream: start validation,
// LSB-first data capture, optional parity check, one or two stop bits.
// Reports the received word, per-frame error flags and a saturating count of
// frames that ended with a parity or stop error.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of uart_rx_frame_checker_if (see interface file)
// -----------------------------------------------------------------------------
module uart_rx_frame_checker
    import uart_rx_frame_checker_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_rx_frame_checker_if.slave bus
);

    localparam logic [CNT_W-1:0]         CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]         CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERRC_ZERO = {ERR_CNT_WIDTH{1'b0}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERRC_ONE  = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_WIDTH-1:0] ERRC_MAX  = {ERR_CNT_WIDTH{1'b1}};

    rx_state_t                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic                     cfg_par_en_q, cfg_par_en_d;
    logic                     cfg_par_odd_q, cfg_par_odd_d;
    logic                     cfg_stop2_q, cfg_stop2_d;
    logic                     par_nxt_q, par_nxt_d;
    logic                     stop_nxt_q, stop_nxt_d;

    logic                     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     dv_q, dv_d;
    logic                     glitch_q, glitch_d;
    logic                     perr_q, perr_d;
    logic                     serr_q, serr_d;
    logic [ERR_CNT_WIDTH-1:0] errc_q, errc_d;

    // Frame-end results before the error-clear override is applied
    logic                     perr_upd_s;
    logic                     serr_upd_s;
    logic [ERR_CNT_WIDTH-1:0] errc_upd_s;
    logic                     par_err_s;
    logic                     par_bit_unused_s;

    // In PARITY the shift register already holds the full word
    uart_rx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (shift_q),
        .par_bit_i (bus.sampled_bit),
        .odd_i     (cfg_par_odd_q),
        .par_bit_o (par_bit_unused_s),
        .par_err_o (par_err_s)
    );

    // Next-state, datapath and output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        cfg_par_en_d  = cfg_par_en_q;
        cfg_par_odd_d = cfg_par_odd_q;
        cfg_stop2_d   = cfg_stop2_q;
        par_nxt_d     = par_nxt_q;
        stop_nxt_d    = stop_nxt_q;
        data_d        = data_q;
        dv_d          = 1'b0;
        glitch_d      = 1'b0;
        perr_upd_s    = perr_q;
        serr_upd_s    = serr_q;
        errc_upd_s    = errc_q;

        case (state_q)
            ST_IDLE: begin
                // Config is frozen here so mid-frame changes have no effect
                if (bus.frame_start) begin
                    state_d       = ST_START;
                    cfg_par_en_d  = bus.par_en;
                    cfg_par_odd_d = bus.par_odd;
                    cfg_stop2_d   = bus.stop2;
                    cnt_d         = CNT_ZERO;
                    par_nxt_d     = 1'b0;
                    stop_nxt_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.sample_valid) begin
                    if (bus.sampled_bit) begin
                        state_d  = ST_IDLE;
                        glitch_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bus.sample_valid) begin
                    // LSB arrives first, so shifting right from the MSB ends aligned
                    shift_d = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bus.sample_valid) begin
                    par_nxt_d = par_err_s;
                    state_d   = ST_STOP1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (bus.sample_valid) begin
                    stop_nxt_d = ~bus.sampled_bit;
                    state_d    = cfg_stop2_q ? ST_STOP2 : ST_DONE;
                end else begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (bus.sample_valid) begin
                    stop_nxt_d = stop_nxt_q | ~bus.sampled_bit;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_STOP2;
                end
            end
            ST_DONE: begin
                perr_upd_s = par_nxt_q & cfg_par_en_q;
                serr_upd_s = stop_nxt_q;
                if (!(par_nxt_q & cfg_par_en_q) && !stop_nxt_q) begin
                    data_d = shift_q;
                    dv_d   = 1'b1;
                end else if (errc_q != ERRC_MAX) begin
                    errc_upd_s = errc_q + ERRC_ONE;
                end else begin
                    errc_upd_s = errc_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear beats a simultaneous frame-end update but never touches the frame itself
        if (!bus.err_clr_n) begin
            perr_d = 1'b0;
            serr_d = 1'b0;
            errc_d = ERRC_ZERO;
        end else begin
            perr_d = perr_upd_s;
            serr_d = serr_upd_s;
            errc_d = errc_upd_s;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            shift_q       <= {DATA_WIDTH{1'b0}};
            cfg_par_en_q  <= 1'b0;
            cfg_par_odd_q <= 1'b0;
            cfg_stop2_q   <= 1'b0;
            par_nxt_q     <= 1'b0;
            stop_nxt_q    <= 1'b0;
            busy_q        <= 1'b0;
            data_q        <= {DATA_WIDTH{1'b0}};
            dv_q          <= 1'b0;
            glitch_q      <= 1'b0;
            perr_q        <= 1'b0;
            serr_q        <= 1'b0;
            errc_q        <= ERRC_ZERO;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            cfg_par_en_q  <= cfg_par_en_d;
            cfg_par_odd_q <= cfg_par_odd_d;
            cfg_stop2_q   <= cfg_stop2_d;
            par_nxt_q     <= par_nxt_d;
            stop_nxt_q    <= stop_nxt_d;
            busy_q        <= busy_d;
            data_q        <= data_d;
            dv_q          <= dv_d;
            glitch_q      <= glitch_d;
            perr_q        <= perr_d;
            serr_q        <= serr_d;
            errc_q        <= errc_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.data_out     = data_q;
    assign bus.data_valid   = dv_q;
    assign bus.start_glitch = glitch_q;
    assign bus.parity_error = perr_q;
    assign bus.stop_error   = serr_q;
    assign bus.err_count    = errc_q;

endmodule
